// File: rtl/scratch_arb_pkg.sv
// rtl/scratch_arb_pkg.sv - shared types and helpers for the scratch memory arbiter
package scratch_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic req_id_t next_id(input req_id_t id);
    return (id == req_id_t'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // First requester at or after ptr in cyclic order; only meaningful when |req.
  function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req, input req_id_t ptr);
    req_id_t c1;
    req_id_t c2;
    c1 = next_id(ptr);
    c2 = next_id(c1);
    if (req[ptr])
      return ptr;
    else if (req[c1])
      return c1;
    else
      return c2;
  endfunction

endpackage

// File: rtl/scratch_mem_arbiter_rd_tag_pipe.sv
// rtl/scratch_mem_arbiter_rd_tag_pipe.sv - valid/ID shift register tracking reads in flight
module rd_tag_pipe
  import scratch_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_valid,
  input  req_id_t push_id,
  output logic    out_valid,
  output req_id_t out_id
);

  logic [DEPTH-1:0] vld;
  req_id_t          id_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      vld[0]  <= push_valid;
      id_q[0] <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        id_q[i] <= id_q[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/scratch_mem_arbiter.sv
// rtl/scratch_mem_arbiter.sv - three-way round-robin burst arbiter for a single-port scratch memory
module scratch_mem_arbiter
  import scratch_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_req,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_req,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_req,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              grant0,
  output logic              grant1,
  output logic              grant2,
  output logic              req0_rd_valid,
  output logic              req1_rd_valid,
  output logic              req2_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state;
  req_id_t            owner;
  req_id_t            rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;
  logic [NUM_REQ-1:0] grant;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] pick_onehot;
  req_id_t            pick;
  logic               own_req;
  logic               own_we;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic               access;
  logic               last_access;
  logic               tag_valid;
  req_id_t            tag_id;

  assign req_vec     = {req2_req, req1_req, req0_req};
  assign pick        = rr_pick(req_vec, rr_ptr);
  assign pick_onehot = NUM_REQ'(1) << pick;

  // Only the owner's inputs ever reach the memory port.
  always_comb begin
    own_req   = req0_req;
    own_we    = req0_we;
    own_addr  = req0_addr;
    own_wdata = req0_wdata;
    case (owner)
      2'd1: begin
        own_req   = req1_req;
        own_we    = req1_we;
        own_addr  = req1_addr;
        own_wdata = req1_wdata;
      end
      2'd2: begin
        own_req   = req2_req;
        own_we    = req2_we;
        own_addr  = req2_addr;
        own_wdata = req2_wdata;
      end
      default: ;
    endcase
  end

  assign access      = grant[owner] && own_req;
  assign last_access = access && (burst_cnt == CNT_W'(MAX_BURST - 1));

  assign mem_en    = access;
  assign mem_we    = access && own_we;
  assign mem_addr  = access ? own_addr : '0;
  assign mem_wdata = access ? own_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            state     <= ST_GRANT;
            owner     <= pick;
            grant     <= pick_onehot;
            burst_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (access) burst_cnt <= burst_cnt + 1'b1;
          // A drop and the final burst access in the same cycle collapse into one release.
          if (!own_req || last_access) begin
            state <= ST_RELEASE;
            grant <= '0;
          end
        end
        ST_RELEASE: begin
          rr_ptr <= next_id(owner);
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .push_valid (mem_en && !mem_we),
    .push_id    (owner),
    .out_valid  (tag_valid),
    .out_id     (tag_id)
  );

  assign grant0        = grant[0];
  assign grant1        = grant[1];
  assign grant2        = grant[2];
  assign req0_rd_valid = tag_valid && (tag_id == req_id_t'(0));
  assign req1_rd_valid = tag_valid && (tag_id == req_id_t'(1));
  assign req2_rd_valid = tag_valid && (tag_id == req_id_t'(2));
  assign rd_data       = mem_rdata;

endmodule
